// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with glitch filter, watchdog and receive FIFO
// Optional E0/F0 prefix folding into per-entry flags: define PS2_BREAK_DECODE_EN.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          ovf_clr,
  output logic                          rd_valid,
  output logic [7:0]                    rd_data,
  output logic                          rd_ext,
  output logic                          rd_brk,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [7:0]                    err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_BREAK_DECODE_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          fclk, fall;
  logic [FW-1:0] filt_cnt;
  state_t        state, state_nx;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout, frame_ok, frame_bad;
  logic          acc_valid;
  logic [7:0]    acc_byte;
  logic          acc_push;
  logic [EW-1:0] entry;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, push_ok, drop;

  // Two-flop synchronisers; reset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;  clk_s2 <= clk_s1;
      dat_s1 <= ps2_data; dat_s2 <= dat_s1;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples; fall is a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fclk     <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == fclk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        fclk     <= clk_s2;
        filt_cnt <= '0;
        fall     <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign timeout   = (state != S_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign frame_ok  = fall && (state == S_STOP) && dat_s2 && (^{shreg, par_bit});
  assign frame_bad = fall && (state == S_STOP) && !(dat_s2 && (^{shreg, par_bit}));

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: watchdog overrides, otherwise advance one step per falling edge.
  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE:   if (!dat_s2) state_nx = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_nx = S_PARITY;
        S_PARITY: state_nx = S_STOP;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  // Frame datapath: bit shifting, watchdog counter, accept strobe and error accounting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      acc_valid <= 1'b0;
      acc_byte  <= '0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      acc_valid <= frame_ok;
      if (frame_ok) acc_byte <= shreg;
      if (state == S_IDLE || fall || timeout) to_cnt <= '0;
      else                                    to_cnt <= to_cnt + TW'(1);
      if (fall && state == S_IDLE) bit_cnt <= '0;
      if (fall && state == S_DATA) begin
        shreg   <= {dat_s2, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (fall && state == S_PARITY) par_bit <= dat_s2;
      frame_err <= frame_bad || timeout;
      if ((frame_bad || timeout) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef PS2_BREAK_DECODE_EN
  logic pend_ext, pend_brk, is_prefix;
  assign is_prefix = (acc_byte == 8'hE0) || (acc_byte == 8'hF0);
  assign acc_push  = acc_valid && !is_prefix;
  assign entry     = {pend_brk, pend_ext, acc_byte};
  assign rd_ext    = mem[rd_ptr][8];
  assign rd_brk    = mem[rd_ptr][9];

  // Pending prefix flags: set by E0/F0, consumed by the next non-prefix byte even if it is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || timeout) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (acc_valid) begin
      if (acc_byte == 8'hE0)      pend_ext <= 1'b1;
      else if (acc_byte == 8'hF0) pend_brk <= 1'b1;
      else begin
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end
    end
  end
`else
  assign acc_push = acc_valid;
  assign entry    = acc_byte;
  assign rd_ext   = 1'b0;
  assign rd_brk   = 1'b0;
`endif

  assign rd_valid = (fifo_level != '0);
  assign rd_data  = mem[rd_ptr][7:0];
  assign pop      = rd_en && rd_valid;
  assign push_ok  = acc_push && ((fifo_level != (AW + 1)'(FIFO_DEPTH)) || pop);
  assign drop     = acc_push && !push_ok;

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= entry;
  end

  // FIFO pointers, occupancy and sticky overflow (a drop beats a same-cycle clear).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + (AW + 1)'(push_ok) - (AW + 1)'(pop);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule
